// File: rtl/alu_pkg.sv
// Shared definitions for the UART/ALU command sequencer: opcode constants,
// FSM state encoding and the opcode legality check.
package alu_pkg;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    function automatic logic op_is_valid(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_check.sv
// Combinational opcode validator: flags whether an opcode belongs to the
// set the ALU implements.
module alu_op_check
    import alu_pkg::*;
#(
    parameter int unsigned NB_OP = OP_W
) (
    input  logic [NB_OP-1:0] op,
    output logic             valid
);

    assign valid = op_is_valid(OP_W'(op));

endmodule

// File: rtl/alu_uart_ctrl.sv
// Command sequencer between UART RX/TX and the ALU: collects A, B, opcode,
// captures the ALU result and sends it. Optional opcode check: ALU_CTRL_OPCHECK_EN.
module alu_uart_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_overrun,
    output logic               o_op_err
);

    state_t state, state_nxt;
    logic   ld_a, ld_b, ld_op, ld_res, set_ovr, op_bad;
    logic   op_valid, op_ok;

    alu_op_check #(
        .NB_OP(NB_OP)
    ) u_op_check (
        .op    (i_rx_data[NB_OP-1:0]),
        .valid (op_valid)
    );

`ifdef ALU_CTRL_OPCHECK_EN
    logic op_err;

    assign op_ok    = op_valid;
    assign o_op_err = op_err;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) op_err <= 1'b0;
        else         op_err <= op_bad;
    end
`else
    logic unused_op_valid;

    assign unused_op_valid = op_valid;
    assign op_ok           = 1'b1;
    assign o_op_err        = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_op     = 1'b0;
        ld_res    = 1'b0;
        set_ovr   = 1'b0;
        op_bad    = 1'b0;
        case (state)
            GET_A: begin
                if (i_rx_done) begin
                    ld_a      = 1'b1;
                    state_nxt = GET_B;
                end
            end
            GET_B: begin
                if (i_rx_done) begin
                    ld_b      = 1'b1;
                    state_nxt = GET_OP;
                end
            end
            GET_OP: begin
                if (i_rx_done) begin
                    if (op_ok) begin
                        ld_op     = 1'b1;
                        state_nxt = EXEC;
                    end else begin
                        op_bad    = 1'b1;
                        state_nxt = GET_A;
                    end
                end
            end
            EXEC: begin
                ld_res    = 1'b1;
                set_ovr   = i_rx_done;
                state_nxt = SEND;
            end
            SEND: begin
                set_ovr   = i_rx_done;
                state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                set_ovr = i_rx_done;
                if (i_tx_done) state_nxt = GET_A;
            end
            default: state_nxt = GET_A;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= GET_A;
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_op  <= '0;
            o_tx_data <= '0;
            o_overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ld_a)    o_alu_a   <= i_rx_data;
            if (ld_b)    o_alu_b   <= i_rx_data;
            if (ld_op)   o_alu_op  <= i_rx_data[NB_OP-1:0];
            if (ld_res)  o_tx_data <= i_alu_result;
            if (set_ovr) o_overrun <= 1'b1;
        end
    end

    // Start pulse is a pure state decode, so it is low out of reset for free.
    assign o_tx_start = (state == SEND);

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Self-checking bench for alu_uart_ctrl: directed command table, reset and
// overrun sequences, then random commands against a behavioural ALU model.
module tb_alu_uart_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] alu_a, alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;
    logic       overrun;
    logic       op_err;

    int n_cmp = 0;
    int n_err = 0;
    int start_cnt = 0;
    int err_cnt = 0;
    logic [5:0] last_op = '0;

    always #5 clk = ~clk;

    alu_uart_ctrl #(
        .NB_DATA(8),
        .NB_OP  (6)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_tx_done    (tx_done),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .i_alu_result (alu_result),
        .o_overrun    (overrun),
        .o_op_err     (op_err)
    );

    // Reference ALU: the result a correct MIPS-style ALU produces for A op B.
    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        int sa;
        case (op)
            6'h20: return 8'((int'(a) + int'(b)) % 256);
            6'h22: return 8'((int'(a) - int'(b) + 256) % 256);
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h03: begin
                sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
                for (int i = 0; i < int'(b) && i < 8; i++)
                    sa = (sa < 0) ? (sa - 1) / 2 : sa / 2;
                return 8'(sa & 255);
            end
            6'h02: return (b >= 8'd8) ? 8'h00 : 8'(int'(a) / (1 << b));
            6'h27: return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        logic [5:0] legal [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};
        foreach (legal[i]) if (legal[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // The ALU fixture that the controller drives.
    always_comb alu_result = ref_alu(alu_a, alu_b, alu_op);

    always @(negedge clk) begin
        if (tx_start) start_cnt++;
        if (op_err)   err_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // Full command; leaves the DUT in WAIT_TX when hold_tx is set.
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input logic [7:0] exp, input string tag, input bit hold_tx);
        int s0;
        int e0;
        logic [5:0] op;
        op = opb[5:0];
        s0 = start_cnt;
        e0 = err_cnt;
        send_byte(a);
        send_byte(b);
        check({tag, " alu_a"}, 32'(alu_a), 32'(a));
        check({tag, " alu_b"}, 32'(alu_b), 32'(b));
        send_byte(opb);
`ifdef ALU_CTRL_OPCHECK_EN
        if (!is_legal(op)) begin
            repeat (4) @(negedge clk);
            check({tag, " op_err pulses"}, 32'(err_cnt - e0), 32'd1);
            check({tag, " no tx_start"}, 32'(start_cnt - s0), 32'd0);
            check({tag, " alu_op kept"}, 32'(alu_op), 32'(last_op));
            return;
        end
`endif
        check({tag, " alu_op"}, 32'(alu_op), 32'(op));
        last_op = op;
        check({tag, " tx_start early"}, 32'(tx_start), 32'd0);
        @(negedge clk);
        check({tag, " tx_start at +2"}, 32'(tx_start), 32'd1);
        check({tag, " tx_data"}, 32'(tx_data), 32'(exp));
        repeat (3) @(negedge clk);
        check({tag, " tx_data held"}, 32'(tx_data), 32'(exp));
        check({tag, " one tx_start"}, 32'(start_cnt - s0), 32'd1);
        check({tag, " op_err quiet"}, 32'(err_cnt - e0), 32'd0);
        if (!hold_tx) pulse_tx_done();
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [5:0] legal_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};
        logic [7:0] ra, rb, rop;

        vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
        vecs[1] = '{8'h03, 8'h05, 8'h22, 8'hFE};
        vecs[2] = '{8'h80, 8'h02, 8'h03, 8'hE0};
        vecs[3] = '{8'h80, 8'h02, 8'h02, 8'h20};
        vecs[4] = '{8'h11, 8'h22, 8'h3F, 8'h00};
        vecs[5] = '{8'h0F, 8'hF0, 8'h25, 8'hFF};
        vecs[6] = '{8'hF0, 8'h3C, 8'h24, 8'h30};
        vecs[7] = '{8'hFF, 8'h0F, 8'h26, 8'hF0};
        vecs[8] = '{8'h10, 8'h01, 8'h27, 8'hEE};
        vecs[9] = '{8'h01, 8'h01, 8'hE0, 8'h02};

        repeat (2) @(negedge clk);
        check("reset tx_data", 32'(tx_data), 32'd0);
        check("reset tx_start", 32'(tx_start), 32'd0);
        check("reset alu_a", 32'(alu_a), 32'd0);
        check("reset alu_op", 32'(alu_op), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        check("reset op_err", 32'(op_err), 32'd0);
        rst = 1'b0;

        check("ADD wrap model", 32'(ref_alu(8'hFF, 8'h02, 6'h20)), 32'h01);

        foreach (vecs[i])
            run_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);

        // Reset mid-command discards the partial A/B.
        send_byte(8'h07);
        send_byte(8'h01);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset alu_a", 32'(alu_a), 32'd0);
        check("midreset alu_b", 32'(alu_b), 32'd0);
        check("midreset alu_op", 32'(alu_op), 32'd0);
        check("midreset tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_op = '0;
        run_cmd(8'h02, 8'h02, 8'h20, 8'h04, "post-reset", 1'b0);
        check("overrun clear", 32'(overrun), 32'd0);

        // Extra byte while waiting for TX.
        run_cmd(8'h01, 8'h02, 8'h20, 8'h03, "ovr1", 1'b1);
        send_byte(8'h55);
        check("overrun set", 32'(overrun), 32'd1);
        check("alu_a untouched", 32'(alu_a), 32'h01);
        pulse_tx_done();

        // Extra byte coincident with tx_done.
        run_cmd(8'h04, 8'h04, 8'h20, 8'h08, "ovr2", 1'b1);
        @(negedge clk);
        rx_data = 8'h55;
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        tx_done = 1'b0;
        check("alu_a not 0x55", 32'(alu_a), 32'h04);
        pulse_tx_done();
        run_cmd(8'h0F, 8'hF0, 8'h25, 8'hFF, "after ovr", 1'b0);
        check("overrun sticky", 32'(overrun), 32'd1);

        // Stray tx_done in GET_A is ignored.
        pulse_tx_done();
        run_cmd(8'h09, 8'h03, 8'h22, 8'h06, "stray tx_done", 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra  = 8'($urandom);
            rb  = (i % 3 == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            rop = (i % 5 == 4) ? 8'($urandom)
                               : {2'($urandom), legal_ops[$urandom_range(0, 7)]};
            run_cmd(ra, rb, rop,
                    is_legal(rop[5:0]) ? ref_alu(ra, rb, rop[5:0]) : 8'h00,
                    $sformatf("rnd%0d", i), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
